// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
// State encoding, control bundle and the load-use rule.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF = '0;

  localparam ctrl_t CTRL_HOLD = '{
    pc_write:      1'b0,
    if_id_write:   1'b0,
    id_ex_write:   1'b0,
    ex_mem_write:  1'b0,
    if_id_flush:   1'b0,
    id_ex_flush:   1'b0,
    mem_wb_bubble: 1'b1
  };

  localparam ctrl_t CTRL_REDIR = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    id_ex_write:   1'b1,
    ex_mem_write:  1'b1,
    if_id_flush:   1'b1,
    id_ex_flush:   1'b1,
    mem_wb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_STALL = '{
    pc_write:      1'b0,
    if_id_write:   1'b0,
    id_ex_write:   1'b1,
    ex_mem_write:  1'b1,
    if_id_flush:   1'b0,
    id_ex_flush:   1'b1,
    mem_wb_bubble: 1'b0
  };

  localparam ctrl_t CTRL_RUN = '{
    pc_write:      1'b1,
    if_id_write:   1'b1,
    id_ex_write:   1'b1,
    ex_mem_write:  1'b1,
    if_id_flush:   1'b0,
    id_ex_flush:   1'b0,
    mem_wb_bubble: 1'b0
  };

  // x0 is hard-wired zero, so a load to it never creates a dependency
  function automatic logic load_use_hit(
    input logic                  mem_read,
    input logic [REG_ADDR_W-1:0] rd,
    input logic [REG_ADDR_W-1:0] rs1,
    input logic [REG_ADDR_W-1:0] rs2,
    input logic                  use1,
    input logic                  use2
  );
    return mem_read && (rd != X0) &&
           ((use1 && (rs1 == rd)) ||
            (use2 && (rs2 == rd)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Hazard controller bus: ID/EX/MEM status in,
// stage enables, flushes and debug counters out.
interface hazard_ctrl_if
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic [REG_ADDR_W-1:0] rs1_id;
  logic [REG_ADDR_W-1:0] rs2_id;
  logic                  use_rs1_id;
  logic                  use_rs2_id;
  logic [REG_ADDR_W-1:0] rd_ex;
  logic                  MemRead_ex;
  logic                  redirect_ex;
  logic                  dmem_req_mem;
  logic                  dmem_ready;

  logic                  pc_write;
  logic                  if_id_write;
  logic                  id_ex_write;
  logic                  ex_mem_write;
  logic                  if_id_flush;
  logic                  id_ex_flush;
  logic                  mem_wb_bubble;
  logic                  mem_timeout;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;
  logic [CNT_W-1:0]      memwait_cnt;

  modport master (
    output rs1_id, rs2_id,
    output use_rs1_id, use_rs2_id,
    output rd_ex, MemRead_ex,
    output redirect_ex,
    output dmem_req_mem, dmem_ready,
    input  pc_write, if_id_write,
    input  id_ex_write, ex_mem_write,
    input  if_id_flush, id_ex_flush,
    input  mem_wb_bubble, mem_timeout,
    input  stall_cnt, flush_cnt,
    input  memwait_cnt
  );

  modport slave (
    input  rs1_id, rs2_id,
    input  use_rs1_id, use_rs2_id,
    input  rd_ex, MemRead_ex,
    input  redirect_ex,
    input  dmem_req_mem, dmem_ready,
    output pc_write, if_id_write,
    output id_ex_write, ex_mem_write,
    output if_id_flush, id_ex_flush,
    output mem_wb_bubble, mem_timeout,
    output stall_cnt, flush_cnt,
    output memwait_cnt
  );

endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter for performance events.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count events, holding at the maximum value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: load-use stall, redirect
// flush, data-memory freeze and timeout detection.
module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  bus
);

  localparam logic [WAIT_W-1:0] LAST =
    WAIT_W'(MEM_TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_nxt;
  logic              tmo_q;
  logic              tmo_nxt;

  logic  load_use;
  logic  err;
  logic  freeze;
  logic  sel_rst;
  logic  sel_err;
  logic  sel_frz;
  logic  sel_red;
  logic  sel_lu;
  logic  sel_run;
  ctrl_t ctrl;

  assign load_use = load_use_hit(
    bus.MemRead_ex, bus.rd_ex,
    bus.rs1_id, bus.rs2_id,
    bus.use_rs1_id, bus.use_rs2_id
  );

  assign err    = (state == ERROR);
  assign freeze = !err && bus.dmem_req_mem &&
                  !bus.dmem_ready;

  // one-hot priority selects; exactly one is set
  assign sel_rst = !reset_n;
  assign sel_err = reset_n && err;
  assign sel_frz = reset_n && freeze;
  assign sel_red = reset_n && !err && !freeze &&
                   bus.redirect_ex;
  assign sel_lu  = reset_n && !err && !freeze &&
                   !bus.redirect_ex && load_use;
  assign sel_run = reset_n && !err && !freeze &&
                   !bus.redirect_ex && !load_use;

  // stage controls decoded from the winning cause
  always_comb begin
    ctrl = CTRL_OFF;
    unique case (1'b1)
      sel_rst: ctrl = CTRL_OFF;
      sel_err: ctrl = CTRL_HOLD;
      sel_frz: ctrl = CTRL_HOLD;
      sel_red: ctrl = CTRL_REDIR;
      sel_lu:  ctrl = CTRL_STALL;
      sel_run: ctrl = CTRL_RUN;
      default: ctrl = CTRL_OFF;
    endcase
  end

  assign bus.pc_write      = ctrl.pc_write;
  assign bus.if_id_write   = ctrl.if_id_write;
  assign bus.id_ex_write   = ctrl.id_ex_write;
  assign bus.ex_mem_write  = ctrl.ex_mem_write;
  assign bus.if_id_flush   = ctrl.if_id_flush;
  assign bus.id_ex_flush   = ctrl.id_ex_flush;
  assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
  assign bus.mem_timeout   = tmo_q;

  // next state: track consecutive freeze cycles
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_q;
    tmo_nxt   = tmo_q;
    unique case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!freeze) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_q == LAST) begin
          state_nxt = ERROR;
          wait_nxt  = wait_q + WAIT_W'(1);
          tmo_nxt   = 1'b1;
        end else begin
          wait_nxt  = wait_q + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // state, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= RUN;
      wait_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      wait_q <= wait_nxt;
      tmo_q  <= tmo_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (sel_lu),
    .count (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (sel_red),
    .count (bus.flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (sel_frz),
    .count (bus.memwait_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed
// sequences then random traffic vs a cycle model.
module tb_hazard_ctrl;

  localparam int TMO  = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    bit         rst_n;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    bit         u1;
    bit         u2;
    bit         mr;
    bit         redir;
    bit         req;
    bit         rdy;
  } stim_t;

  typedef struct {
    logic [6:0] ctrl;
    bit         tmo;
    int         stall;
    int         flush;
    int         memw;
  } exp_t;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.CNT_W(CW)) bus ();

  hazard_ctrl #(
    .MEM_TIMEOUT (TMO),
    .WAIT_W      (8),
    .CNT_W       (CW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_chk;
  int   n_fail;

  // reference model: error flag, freeze run length,
  // saturating event tallies
  bit m_err;
  int m_run;
  bit m_tmo;
  int m_stall;
  int m_flush;
  int m_memw;

  function automatic stim_t st(
    bit rn, int rs1, int rs2, int rd,
    bit u1, bit u2, bit mr, bit redir,
    bit req, bit rdy
  );
    stim_t s;
    s.rst_n = rn;
    s.rs1   = 5'(rs1);
    s.rs2   = 5'(rs2);
    s.rd    = 5'(rd);
    s.u1    = u1;
    s.u2    = u2;
    s.mr    = mr;
    s.redir = redir;
    s.req   = req;
    s.rdy   = rdy;
    return s;
  endfunction

  function automatic int sat(int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_clear();
    m_err   = 0;
    m_run   = 0;
    m_tmo   = 0;
    m_stall = 0;
    m_flush = 0;
    m_memw  = 0;
  endtask

  // drive one cycle and queue the expected response
  task automatic step(input stim_t s);
    exp_t e;
    bit   fz;
    bit   lu;
    @(negedge clk);
    #1;
    reset_n          = s.rst_n;
    bus.rs1_id       = s.rs1;
    bus.rs2_id       = s.rs2;
    bus.rd_ex        = s.rd;
    bus.use_rs1_id   = s.u1;
    bus.use_rs2_id   = s.u2;
    bus.MemRead_ex   = s.mr;
    bus.redirect_ex  = s.redir;
    bus.dmem_req_mem = s.req;
    bus.dmem_ready   = s.rdy;
    if (!s.rst_n) model_clear();
    fz = !m_err && s.req && !s.rdy;
    lu = s.mr && (s.rd != 0) &&
         ((s.u1 && s.rs1 == s.rd) ||
          (s.u2 && s.rs2 == s.rd));
    if (!s.rst_n)    e.ctrl = 7'b0000000;
    else if (m_err)  e.ctrl = 7'b0000001;
    else if (fz)     e.ctrl = 7'b0000001;
    else if (s.redir) e.ctrl = 7'b1111110;
    else if (lu)     e.ctrl = 7'b0011010;
    else             e.ctrl = 7'b1111000;
    e.tmo   = m_tmo;
    e.stall = m_stall;
    e.flush = m_flush;
    e.memw  = m_memw;
    exp_q.push_back(e);
    if (s.rst_n && !m_err) begin
      if (fz) begin
        m_run  = m_run + 1;
        m_memw = sat(m_memw);
        if (m_run >= TMO) begin
          m_err = 1;
          m_tmo = 1;
        end
      end else begin
        m_run = 0;
        if (s.redir)   m_flush = sat(m_flush);
        else if (lu)   m_stall = sat(m_stall);
      end
    end
  endtask

  task automatic check(string nm, int act, int req);
    n_chk = n_chk + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s at %0t: got %0h, required %0h",
               nm, $time, act, req);
    end
  endtask

  // monitor: compare mid-cycle, away from clk edges
  initial begin
    exp_t e;
    logic [6:0] c;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        c = {bus.pc_write, bus.if_id_write,
             bus.id_ex_write, bus.ex_mem_write,
             bus.if_id_flush, bus.id_ex_flush,
             bus.mem_wb_bubble};
        check("ctrl", int'(c), int'(e.ctrl));
        check("mem_timeout", int'(bus.mem_timeout),
              int'(e.tmo));
        check("stall_cnt", int'(bus.stall_cnt), e.stall);
        check("flush_cnt", int'(bus.flush_cnt), e.flush);
        check("memwait_cnt", int'(bus.memwait_cnt),
              e.memw);
      end
    end
  end

  stim_t idle;
  stim_t rst;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_clear();
    reset_n          = 1'b0;
    bus.rs1_id       = '0;
    bus.rs2_id       = '0;
    bus.rd_ex        = '0;
    bus.use_rs1_id   = 1'b0;
    bus.use_rs2_id   = 1'b0;
    bus.MemRead_ex   = 1'b0;
    bus.redirect_ex  = 1'b0;
    bus.dmem_req_mem = 1'b0;
    bus.dmem_ready   = 1'b0;
    idle = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst  = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (3) step(rst);
    repeat (2) step(idle);

    // load-use on rs1, then load proceeds in MEM
    step(st(1, 5, 0, 5, 1, 0, 1, 0, 0, 0));
    step(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(idle);

    // load to x0 never stalls
    step(st(1, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    step(idle);

    // redirect wins over a same-cycle load-use
    step(st(1, 7, 0, 7, 1, 0, 1, 1, 0, 0));
    step(idle);

    // three wait cycles then ready
    repeat (3) step(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step(idle);

    // freeze holds a pending redirect and load-use
    step(st(1, 3, 3, 3, 1, 1, 1, 1, 1, 0));
    step(st(1, 3, 3, 3, 1, 1, 1, 1, 1, 1));
    step(idle);

    // timeout: ready never comes
    repeat (7) step(st(1, 2, 0, 2, 1, 0, 1, 1, 1, 0));
    step(st(1, 2, 0, 2, 1, 0, 1, 1, 0, 0));
    step(rst);
    repeat (2) step(idle);

    // saturate stall_cnt, then reset mid-freeze
    repeat (5) step(st(1, 0, 9, 9, 0, 1, 1, 0, 0, 0));
    repeat (2) step(st(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    step(idle);

    // random traffic with tight register aliasing
    for (int i = 0; i < 3000; i++) begin
      step(st(
        $urandom_range(0, 99) != 0,
        int'($urandom_range(0, 3)),
        int'($urandom_range(0, 3)),
        int'($urandom_range(0, 3)),
        $urandom_range(0, 1) == 1,
        $urandom_range(0, 1) == 1,
        $urandom_range(0, 1) == 1,
        $urandom_range(0, 4) == 0,
        $urandom_range(0, 2) == 0,
        $urandom_range(0, 2) != 0));
    end

    for (int w = 0; w < 10; w++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #5;
    if (exp_q.size() != 0) begin
      n_chk  = n_chk + 1;
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d pending, required 0",
               exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core. Sits beside the forwarding unit.
- Resolves the hazards forwarding cannot cover:
  - load-use stall in ID;
  - control redirect flush from EX;
  - whole-pipe freeze while the data memory in MEM is not ready.
- Drives per-stage write enables and flushes, detects data-memory timeout, and keeps saturating event counters for performance debug.

Parameters:
- MEM_TIMEOUT, 64: max consecutive freeze cycles before error; legal range 2..(2^WAIT_W - 1).
- WAIT_W, 8: width of the internal wait counter.
- CNT_W, 16: width of each event counter.

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- rs1_id  in  5  rs1 of instruction in ID
- rs2_id  in  5  rs2 of instruction in ID
- use_rs1_id  in  1  ID instruction reads rs1
- use_rs2_id  in  1  ID instruction reads rs2
- rd_ex  in  5  destination of instruction in EX
- MemRead_ex  in  1  EX instruction is a load
- redirect_ex  in  1  taken branch or jump resolved in EX
- dmem_req_mem  in  1  MEM instruction accesses data memory
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- ex_mem_write  out  1  EX/MEM register enable
- if_id_flush  out  1  load NOP into IF/ID
- id_ex_flush  out  1  load NOP into ID/EX
- mem_wb_bubble  out  1  load NOP into MEM/WB
- mem_timeout  out  1  sticky error flag
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  redirect cycles
- memwait_cnt  out  CNT_W  freeze cycles

Behaviour:
- Clock and reset: single clock, clk; reset is asynchronous, active-low, on reset_n.
- Reset state while reset_n=0 (and on assertion mid-operation):
  - state=RUN;
  - wait counter, all event counters and mem_timeout cleared to 0;
  - all write enables, flushes and mem_wb_bubble driven 0.
- States:
  - RUN: normal operation.
  - MEM_WAIT: pipe frozen on data memory.
  - ERROR: terminal; exit only via reset.
- Definitions:
  - load_use = MemRead_ex & (rd_ex!=0) & ((use_rs1_id & rs1_id==rd_ex) | (use_rs2_id & rs2_id==rd_ex)).
  - freeze = (state!=ERROR) & dmem_req_mem & ~dmem_ready.
- Outputs are combinational from state and inputs, with zero-cycle latency. They are evaluated by priority, first match wins:
  1. ERROR: all enables 0, all flushes 0, mem_wb_bubble=1.
  2. freeze: pc_write, if_id_write, id_ex_write and ex_mem_write all 0; mem_wb_bubble=1; no flush. A pending redirect_ex or load_use is held, not lost, because the stages are frozen.
  3. redirect_ex: all enables 1, if_id_flush=1, id_ex_flush=1. Any load_use in the same cycle is ignored, because the ID instruction is squashed.
  4. load_use: pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1 (bubble), ex_mem_write=1.
  5. Otherwise: all enables 1, flushes 0, mem_wb_bubble=0.
- Transitions:
  - RUN -> MEM_WAIT on freeze; wait counter loads 1.
  - MEM_WAIT with freeze still high: wait counter +1.
  - MEM_WAIT -> ERROR when the counter reaches MEM_TIMEOUT with freeze still high; mem_timeout sets 1 on that edge.
  - MEM_WAIT -> RUN when dmem_ready=1 (freeze low); wait counter cleared. Enables are already released in that same cycle.
  - A single-cycle access (dmem_ready=1 on the request cycle) never leaves RUN.
- Counters, each incremented once per cycle in which its cause wins priority:
  - stall_cnt for load_use;
  - flush_cnt for redirect;
  - memwait_cnt for freeze.
  - Each saturates at 2^CNT_W-1; no wrap.
  - Counters do not advance in ERROR.
- rd_ex=0 never causes a stall, even when MemRead_ex=1.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - state enum {RUN, MEM_WAIT, ERROR};
  - REG_ADDR_W=5;
  - constant X0=5'd0.
- Natural sub-module: sat_counter, parameterised width with inc input and saturating count; instantiated 3x.

Test Plan:
- Load-use: MemRead_ex=1, rd_ex=5, rs1_id=5, use_rs1_id=1 for 1 cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_cnt=1; next cycle (load in MEM) all enables 1.
- rd_ex=0 with rs2_id=0, use_rs2_id=1, MemRead_ex=1 -> no stall, stall_cnt stays 0.
- Redirect plus load-use in the same cycle -> if_id_flush=1, id_ex_flush=1, pc_write=1; flush_cnt=1, stall_cnt=0.
- dmem_req_mem=1 with dmem_ready low for 3 cycles then high:
  - 3 cycles of all enables 0 and mem_wb_bubble=1;
  - enables return to 1 in the ready cycle;
  - memwait_cnt=3, state back to RUN.
- MEM_TIMEOUT=4, dmem_ready held 0:
  - mem_timeout rises at the 4th freeze edge and stays 1 with enables 0;
  - reset_n pulse clears it and restores RUN.
- CNT_W=2, 5 consecutive load-use cycles -> stall_cnt saturates at 3; async reset_n low mid-freeze clears all counters immediately without waiting for a clk edge.
